// File: rtl/store_buffer_v2_pkg.sv
// store_buffer_v2_pkg: entry layout and sizing helpers shared by the store buffer and its forward merge.
package store_buffer_v2_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int WAY_NUM = 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WORD_OFS = $clog2(STRB_W);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0] strb;
    logic uncached;
    logic [WAY_NUM-1:0] hit;
    logic valid;
  } sb_entry_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sb_fwd_merge.sv
// sb_fwd_merge: youngest-wins byte merge of matching valid entries, walked oldest to youngest from head.
module sb_fwd_merge
  import store_buffer_v2_pkg::*;
#(parameter int SB_DEPTH = 4) (
  input  sb_entry_t                     i_ents [SB_DEPTH],
  input  logic [$clog2(SB_DEPTH)-1:0]   i_head,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  output logic [STRB_W-1:0]             o_hit,
  output logic [DATA_WIDTH-1:0]         o_data
);
  localparam int IW = $clog2(SB_DEPTH);
  logic [IW-1:0] w_idx;
  logic w_unused;
  always_comb begin
    o_hit = '0;
    o_data = '0;
    w_idx = i_head;
    w_unused = ^i_addr[WORD_OFS-1:0];
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_idx = i_head + IW'(k);
      w_unused = w_unused ^ i_ents[k].uncached ^ (^i_ents[k].hit) ^ (^i_ents[k].addr[WORD_OFS-1:0]);
      if (i_ents[w_idx].valid && i_ents[w_idx].addr[ADDR_WIDTH-1:WORD_OFS] == i_addr[ADDR_WIDTH-1:WORD_OFS])
        for (int b = 0; b < STRB_W; b++)
          if (i_ents[w_idx].strb[b]) begin
            o_hit[b] = 1'b1;
            o_data[b*8 +: 8] = i_ents[w_idx].data[b*8 +: 8];
          end
    end
  end
endmodule

// File: rtl/store_buffer_v2.sv
// store_buffer_v2: circular store FIFO with speculative/committed split, in-order drain and byte forwarding.
module store_buffer_v2
  import store_buffer_v2_pkg::*;
#(parameter int SB_DEPTH = 4) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_i,
  input  logic                            enq_valid_i,
  output logic                            enq_ready_o,
  input  logic [ADDR_WIDTH-1:0]           enq_addr_i,
  input  logic [DATA_WIDTH-1:0]           enq_data_i,
  input  logic [STRB_W-1:0]               enq_strb_i,
  input  logic                            enq_uncached_i,
  input  logic [WAY_NUM-1:0]              enq_hit_i,
  input  logic                            commit_i,
  output logic                            drain_valid_o,
  input  logic                            drain_ready_i,
  output sb_entry_t                       drain_entry_o,
  input  logic [ADDR_WIDTH-1:0]           fwd_addr_i,
  output logic [STRB_W-1:0]               fwd_hit_o,
  output logic [DATA_WIDTH-1:0]           fwd_data_o,
  output logic [$clog2(SB_DEPTH):0]       count_o,
  output logic [$clog2(SB_DEPTH):0]       spec_cnt_o,
  output logic                            empty_o
);
  localparam int IW = $clog2(SB_DEPTH);
  localparam int PW = ptr_w(SB_DEPTH);
  sb_entry_t r_ent [SB_DEPTH];
  logic [PW-1:0] r_head, r_cmt, r_tail, w_cmt_nxt, w_spec;
  logic w_enq, w_cmt, w_drain;
  logic [SB_DEPTH-1:0] w_kill;
  assign w_spec = r_tail - r_cmt;
  assign count_o = r_tail - r_head;
  assign spec_cnt_o = w_spec;
  assign empty_o = r_tail == r_head;
  assign enq_ready_o = !((r_tail[IW-1:0] == r_head[IW-1:0]) && (r_tail[IW] != r_head[IW]));
  assign drain_valid_o = r_head != r_cmt;
  assign drain_entry_o = r_ent[r_head[IW-1:0]];
  assign w_enq = enq_valid_i && enq_ready_o && !flush_i;
  assign w_cmt = commit_i && (w_spec != '0);
  assign w_drain = drain_valid_o && drain_ready_i;
  assign w_cmt_nxt = r_cmt + PW'(w_cmt);
  // an entry is flushed if it still lies in [cmt, tail) once this cycle's commit is applied
  always_comb begin
    w_kill = '0;
    for (int i = 0; i < SB_DEPTH; i++)
      w_kill[i] = flush_i && (PW'(IW'(IW'(i) - w_cmt_nxt[IW-1:0])) < PW'(r_tail - w_cmt_nxt));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_cmt <= '0;
      r_tail <= '0;
      for (int i = 0; i < SB_DEPTH; i++) r_ent[i].valid <= 1'b0;
    end else begin
      r_head <= r_head + PW'(w_drain);
      r_cmt <= w_cmt_nxt;
      r_tail <= flush_i ? w_cmt_nxt : r_tail + PW'(w_enq);
      for (int i = 0; i < SB_DEPTH; i++) if (w_kill[i]) r_ent[i].valid <= 1'b0;
      if (w_drain) r_ent[r_head[IW-1:0]].valid <= 1'b0;
      if (w_enq) r_ent[r_tail[IW-1:0]] <= '{addr: enq_addr_i, data: enq_data_i, strb: enq_strb_i,
                                             uncached: enq_uncached_i, hit: enq_hit_i, valid: 1'b1};
    end
  end
  sb_fwd_merge #(.SB_DEPTH(SB_DEPTH)) u_fwd (
    .i_ents(r_ent),
    .i_head(r_head[IW-1:0]),
    .i_addr(fwd_addr_i),
    .o_hit(fwd_hit_o),
    .o_data(fwd_data_o)
  );
endmodule

// File: tb/tb_store_buffer_v2.sv
// tb_store_buffer_v2: scoreboard bench; a reference queue tracks live stores and is popped on each drain.
module tb_store_buffer_v2;
  import store_buffer_v2_pkg::*;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b1, flush_i = 1'b0, enq_valid_i = 1'b0, commit_i = 1'b0;
  logic drain_ready_i = 1'b0, enq_uncached_i = 1'b0;
  logic [31:0] enq_addr_i = '0, enq_data_i = '0, fwd_addr_i = '0;
  logic [3:0] enq_strb_i = '0;
  logic [1:0] enq_hit_i = 2'b01;
  logic enq_ready_o, drain_valid_o, empty_o;
  sb_entry_t drain_entry_o;
  logic [3:0] fwd_hit_o;
  logic [31:0] fwd_data_o;
  logic [2:0] count_o, spec_cnt_o;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} m_t;
  m_t mq[$];
  int mspec = 0;
  int n_chk = 0, n_pass = 0;

  store_buffer_v2 #(.SB_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_addr_i(enq_addr_i), .enq_data_i(enq_data_i), .enq_strb_i(enq_strb_i),
    .enq_uncached_i(enq_uncached_i), .enq_hit_i(enq_hit_i), .commit_i(commit_i),
    .drain_valid_o(drain_valid_o), .drain_ready_i(drain_ready_i), .drain_entry_o(drain_entry_o),
    .fwd_addr_i(fwd_addr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
    .count_o(count_o), .spec_cnt_o(spec_cnt_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && commit_i) assert (spec_cnt_o != '0) else $error("FAIL commit_without_spec");

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input bit e, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit c, input bit f, input bit dr, input bit r);
    bit dv, rdy;
    enq_valid_i = e; enq_addr_i = a; enq_data_i = d; enq_strb_i = s;
    commit_i = c; flush_i = f; drain_ready_i = dr; rst = r;
    #3;
    dv = mq.size() > mspec;
    rdy = mq.size() < D;
    chk("count", 64'(count_o), 64'(mq.size()));
    chk("spec_cnt", 64'(spec_cnt_o), 64'(mspec));
    chk("empty", 64'(empty_o), 64'(mq.size() == 0));
    chk("enq_ready", 64'(enq_ready_o), 64'(rdy));
    chk("drain_valid", 64'(drain_valid_o), 64'(dv));
    if (dv) begin
      chk("drain_addr", 64'(drain_entry_o.addr), 64'(mq[0].a));
      chk("drain_data", 64'(drain_entry_o.data), 64'(mq[0].d));
      chk("drain_strb", 64'(drain_entry_o.strb), 64'(mq[0].s));
    end
    if (r) begin
      mq.delete();
      mspec = 0;
    end else begin
      if (dv && dr) void'(mq.pop_front());
      if (c && mspec > 0) mspec--;
      if (f) begin
        repeat (mspec) void'(mq.pop_back());
        mspec = 0;
      end else if (e && rdy) begin
        mq.push_back('{a: a, d: d, s: s});
        mspec++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s); step(1, a, d, s, 0, 0, 0, 0); endtask
  task automatic cm(); step(0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic dn(); step(0, 0, 0, 0, 0, 0, 1, 0); endtask

  task automatic fwd_chk(input logic [31:0] a);
    logic [3:0] h = '0;
    logic [31:0] dd = '0;
    fwd_addr_i = a;
    #1;
    foreach (mq[i])
      if (mq[i].a[31:2] == a[31:2])
        for (int b = 0; b < 4; b++)
          if (mq[i].s[b]) begin
            h[b] = 1'b1;
            dd[b*8 +: 8] = mq[i].d[b*8 +: 8];
          end
    chk("fwd_hit", 64'(fwd_hit_o), 64'(h));
    chk("fwd_data", 64'(fwd_data_o), 64'(dd));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    fwd_chk(32'h0);
    enq(32'h1000, 32'hAABBCCDD, 4'hF);
    idle();
    fwd_chk(32'h1000);
    cm();
    dn();
    idle();
    chk("empty_after_drain", 64'(empty_o), 64'd1);
    enq(32'h2000, 32'h11111111, 4'hF);
    enq(32'h2000, 32'h00002200, 4'b0010);
    fwd_chk(32'h2002);
    chk("fwd_merge_const", 64'(fwd_data_o), 64'h11112211);
    cm();
    cm();
    dn();
    dn();
    idle();
    for (int i = 0; i < 4; i++) enq(32'h3000 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
    idle();
    chk("full_not_ready", 64'(enq_ready_o), 64'd0);
    fwd_chk(32'h3008);
    cm();
    step(1, 32'h3100, 32'h55, 4'hF, 0, 0, 1, 0);
    step(1, 32'h3100, 32'h55, 4'hF, 0, 0, 0, 0);
    idle();
    chk("wrap_count", 64'(count_o), 64'd4);
    repeat (4) step(0, 0, 0, 0, 1, 0, 1, 0);
    repeat (2) dn();
    idle();
    enq(32'h4000, 32'hA, 4'hF);
    enq(32'h4004, 32'hB, 4'hF);
    enq(32'h4008, 32'hC, 4'hF);
    cm();
    step(0, 0, 0, 0, 1, 1, 0, 0);
    idle();
    fwd_chk(32'h4008);
    dn();
    dn();
    idle();
    enq(32'h5000, 32'hD, 4'h3);
    cm();
    step(1, 32'h5004, 32'hE, 4'hF, 0, 1, 0, 0);
    repeat (5) idle();
    dn();
    idle();
    enq(32'h6000, 32'h60, 4'hF);
    enq(32'h6004, 32'h64, 4'hF);
    enq(32'h6008, 32'h68, 4'hF);
    repeat (3) cm();
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    fwd_chk(32'h6000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/store_buffer_v2.md
Name: store_buffer_v2

Overview:
- Parametrised successor to the dcache store buffer: circular FIFO of pending stores between LSU M1 stage and dcache write port.
- Entries are speculative until commit, then committed. Flush discards only speculative entries.
- Committed entries drain in order through a valid/ready port.
- Combinational youngest-wins byte forwarding to loads across all live entries.

Parameters:
SB_DEPTH, 4, entry count; power of two, >=2
ADDR_WIDTH, 32, physical address width
DATA_WIDTH, 32, store data width; multiple of 8
WAY_NUM, 2, cache ways recorded per entry

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  discard all speculative entries
enq_valid_i  in  1  store from M1 valid
enq_ready_o  out  1  buffer can accept
enq_addr_i  in  ADDR_WIDTH  store paddr
enq_data_i  in  DATA_WIDTH  store data
enq_strb_i  in  DATA_WIDTH/8  byte enables
enq_uncached_i  in  1  uncached store
enq_hit_i  in  WAY_NUM  way hit vector from M1
commit_i  in  1  commit oldest speculative entry
drain_valid_o  out  1  head entry committed and valid
drain_ready_i  in  1  cache accepts head
drain_entry_o  out  sb_entry_t  head entry fields
fwd_addr_i  in  ADDR_WIDTH  load paddr
fwd_hit_o  out  DATA_WIDTH/8  per-byte forward hit
fwd_data_o  out  DATA_WIDTH  forwarded bytes (0 where no hit)
count_o  out  $clog2(SB_DEPTH)+1  live entries
spec_cnt_o  out  $clog2(SB_DEPTH)+1  speculative entries
empty_o  out  1  count_o==0

Behaviour:
- Pointers head (oldest), cmt (oldest speculative), tail (next free), each with an extra wrap bit.
- Invariant: head <= cmt <= tail in queue order.
- Reset: all pointers 0, all entry valid bits 0.
  - Outputs after reset: enq_ready_o=1, drain_valid_o=0, fwd_hit_o=0, fwd_data_o=0, count_o=0, spec_cnt_o=0, empty_o=1.
- enq_ready_o = !full, from registered pointers only. No same-cycle bypass from a drain.
- Enqueue fires on enq_valid_i & enq_ready_o & !flush_i.
  - Writes entry[tail] as valid and speculative; tail++.
  - Enqueue coincident with flush is dropped.
- Commit: commit_i with spec_cnt>0 increments cmt. commit_i with spec_cnt==0 is ignored; the bench asserts it never occurs.
- Flush: tail <= cmt (after any same-cycle commit) and speculative valid bits are cleared.
  - Committed entries survive and keep draining.
- Same-cycle priority: commit applied, then flush, then enqueue (blocked by flush).
- Drain:
  - drain_valid_o = (head != cmt); drain_entry_o = entry[head].
  - Fire on drain_valid_o & drain_ready_i: head++ and the entry is invalidated.
  - drain_entry_o is stable while valid & !ready.
- Drain, commit and enqueue may all fire in one cycle; count_o updates by +enq-drain.
- Forwarding (combinational, same cycle):
  - Matches valid entries where entry.addr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)] equals fwd_addr_i word address.
  - Per byte, the youngest matching entry whose strb bit is set wins; older entries are overridden byte-wise.
  - An entry draining this cycle still forwards.
  - An entry enqueued this cycle does not forward until the next cycle.
- Wrap-around: pointer index = low bits. Full = index equal with wrap bits different; empty = index equal with wrap bits equal.
- Reset asserted mid-drain: the buffer is empty next cycle and drain_valid_o=0 regardless of drain_ready_i.

Decomposition:
- Shared package: sb_entry_t {addr, data, strb, uncached, hit[WAY_NUM], valid}, pointer width function, word-offset constant.
- One sub-module: sb_fwd_merge. It is a combinational youngest-wins byte merge over SB_DEPTH entries, ordered by age relative to head.

Test Plan:
- Reset, then enqueue 0x1000/0xAABBCCDD/strb 4'hF without commit -> drain_valid_o=0, spec_cnt_o=1. Commit -> drain_valid_o=1 next cycle; drain_ready_i=1 -> empty_o=1.
- Enqueue 0x2000 data 0x11111111 strb F, then 0x2000 data 0x00002200 strb 4'b0010 -> fwd_addr_i=0x2002: fwd_hit_o=4'hF, fwd_data_o=0x11112211.
- Fill 4 entries -> enq_ready_o=0. Drain one in the same cycle enq_valid_i=1 -> that enqueue is not accepted; accepted next cycle. Pointers wrap and count_o=4.
- Enqueue A,B,C; commit A; flush_i with commit_i for B -> A and B drain in order, C is gone, spec_cnt_o=0.
- Enqueue coincident with flush_i -> count_o unchanged. Hold drain_ready_i=0 for 5 cycles -> drain_entry_o stable.
- Assert rst with 3 committed entries while drain_ready_i=1 -> next cycle count_o=0, drain_valid_o=0, fwd_hit_o=0.
